// File: rtl/match_pkg.sv
// match_pkg: shared state encoding, bus defaults and helpers for match_engine.
// Build option MATCH_WRITEBACK_EN selects the result store to RESULT_ADDR.
package match_pkg;

    localparam int CHAR_W = 8;

    localparam logic [31:0] DEF_TEXT_BASE   = 32'h0000_0000;
    localparam logic [31:0] DEF_PAT_BASE    = 32'h0000_0400;
    localparam logic [31:0] DEF_RESULT_ADDR = 32'h4000_0010;
    localparam int          DEF_TEXT_MAX    = 256;
    localparam int          DEF_PAT_MAX     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAT,
        SCAN,
        WRITE,
        DONE
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/match_window.sv
// match_window: sliding window of recent text chars plus cached pattern.
// hit_o compares the window as it will look after char_i is shifted in.
module match_window
    import match_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int PLW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              cache_we_i,
    input  logic [PLW-1:0]    idx_i,
    input  logic [PLW-1:0]    plen_i,
    input  logic [CHAR_W-1:0] char_i,
    output logic              hit_o
);

    logic [CHAR_W-1:0] win_q [PAT_MAX];
    logic [CHAR_W-1:0] pat_q [PAT_MAX];
    logic [CHAR_W-1:0] win_d [PAT_MAX];

    always_comb begin
        win_d[0] = char_i;
        for (int i = 1; i < PAT_MAX; i++) begin
            win_d[i] = win_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAT_MAX; i++) begin
                win_q[i] <= '0;
                pat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PAT_MAX; i++) begin
                if (clr_i) begin
                    win_q[i] <= '0;
                end else if (shift_i) begin
                    win_q[i] <= win_d[i];
                end
                if (cache_we_i && 32'(idx_i) == i) begin
                    pat_q[i] <= char_i;
                end
            end
        end
    end

    // Newest char sits at index 0, so window[j] pairs with pattern[plen-1-j].
    always_comb begin
        hit_o = 1'b1;
        for (int j = 0; j < PAT_MAX; j++) begin
            for (int m = 0; m < PAT_MAX; m++) begin
                if (j < 32'(plen_i) && m == 32'(plen_i) - 1 - j &&
                    win_d[j] != pat_q[m]) begin
                    hit_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/match_engine.sv
// match_engine: bus initiator counting pattern occurrences in a text in DataMEM.
// Define MATCH_WRITEBACK_EN to store the count to RESULT_ADDR after the scan.
module match_engine
    import match_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE   = DEF_TEXT_BASE,
    parameter logic [31:0] PAT_BASE    = DEF_PAT_BASE,
    parameter int          TEXT_MAX    = DEF_TEXT_MAX,
    parameter int          PAT_MAX     = DEF_PAT_MAX,
    parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] match_count,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Read_data
);

    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int TW  = $clog2(TEXT_MAX + 1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mrd_q, mrd_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [PLW-1:0]    plen_q, plen_d;
    logic [PLW-1:0]    k_q, k_d;
    logic [TW-1:0]     t_q, t_d;
    logic              fin;
    logic              win_clr, win_shift, cache_we, hit;
    logic [CHAR_W-1:0] rchar;
    logic              unused_rd;

    assign rchar     = Read_data[CHAR_W-1:0];
    assign unused_rd = ^Read_data[31:CHAR_W];

`ifdef MATCH_WRITEBACK_EN
    logic        mwr_q, mwr_d;
    logic [31:0] wdata_q, wdata_d;
`endif

    match_window #(
        .PAT_MAX(PAT_MAX),
        .PLW    (PLW)
    ) u_win (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (win_clr),
        .shift_i   (win_shift),
        .cache_we_i(cache_we),
        .idx_i     (k_q),
        .plen_i    (plen_q),
        .char_i    (rchar),
        .hit_o     (hit)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mrd_d     = 1'b0;
        addr_d    = '0;
        cnt_d     = cnt_q;
        plen_d    = plen_q;
        k_d       = k_q;
        t_d       = t_q;
        fin       = 1'b0;
        win_clr   = 1'b0;
        win_shift = 1'b0;
        cache_we  = 1'b0;
`ifdef MATCH_WRITEBACK_EN
        mwr_d     = 1'b0;
        wdata_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_PAT;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    plen_d  = '0;
                    k_d     = '0;
                    t_d     = '0;
                    win_clr = 1'b1;
                    mrd_d   = 1'b1;
                    addr_d  = PAT_BASE;
                end
            end
            LOAD_PAT: begin
                if (rchar == '0) begin
                    plen_d = k_q;
                    if (k_q == '0) begin
                        fin = 1'b1;
                    end else begin
                        state_d = SCAN;
                        mrd_d   = 1'b1;
                        addr_d  = TEXT_BASE;
                    end
                end else begin
                    cache_we = 1'b1;
                    if (32'(k_q) == PAT_MAX - 1) begin
                        // Overlong pattern: keep the first PAT_MAX chars.
                        plen_d  = PLW'(PAT_MAX);
                        state_d = SCAN;
                        mrd_d   = 1'b1;
                        addr_d  = TEXT_BASE;
                    end else begin
                        k_d    = k_q + PLW'(1);
                        mrd_d  = 1'b1;
                        addr_d = PAT_BASE + 32'({k_d, 2'b00});
                    end
                end
            end
            SCAN: begin
                if (rchar == '0) begin
                    fin = 1'b1;
                end else begin
                    win_shift = 1'b1;
                    if (hit && 32'(t_q) + 1 >= 32'(plen_q)) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                    if (32'(t_q) == TEXT_MAX - 1) begin
                        fin = 1'b1;
                    end else begin
                        t_d    = t_q + TW'(1);
                        mrd_d  = 1'b1;
                        addr_d = TEXT_BASE + 32'({t_d, 2'b00});
                    end
                end
            end
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (fin) begin
`ifdef MATCH_WRITEBACK_EN
            state_d = WRITE;
            mwr_d   = 1'b1;
            addr_d  = RESULT_ADDR;
            wdata_d = {16'b0, cnt_d};
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mrd_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            plen_q  <= '0;
            k_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mrd_q   <= mrd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
            k_q     <= k_d;
            t_q     <= t_d;
        end
    end

`ifdef MATCH_WRITEBACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mwr_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            mwr_q   <= mwr_d;
            wdata_q <= wdata_d;
        end
    end

    assign MemWrite   = mwr_q;
    assign Write_data = wdata_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^RESULT_ADDR;
    assign MemWrite   = 1'b0;
    assign Write_data = '0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign MemRead     = mrd_q;
    assign Address     = addr_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_match_engine.sv
// tb_match_engine: table vectors, corner sequences and random runs for match_engine.
// Honours MATCH_WRITEBACK_EN the same way the design does.
module tb_match_engine;

    localparam logic [31:0] PAT_BASE = 32'h0000_0400;
    localparam logic [31:0] RES_ADDR = 32'h4000_0010;
    localparam int          PAT_MAX  = 8;
`ifdef MATCH_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    typedef logic [8*40-1:0] str_t;
    typedef struct packed {
        str_t        text;
        str_t        pat;
        logic [15:0] cnt;
        logic [15:0] preads;
        logic [15:0] treads;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, MemRead, MemWrite;
    logic [15:0] match_count;
    logic [31:0] Address, Write_data, Read_data;
    logic [31:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;
    int pr_cnt = 0, tr_cnt = 0, wr_cnt = 0, dn_cnt = 0, proto_err = 0;
    logic [31:0] last_wa = '0, last_wd = '0;

    always #5 clk = ~clk;

    assign Read_data = (Address[31:12] == '0) ? mem[Address[11:2]] : 32'h0;

    match_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .match_count(match_count),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data)
    );

    always @(negedge clk) begin
        if (MemRead) begin
            if (Address >= PAT_BASE) pr_cnt++;
            else tr_cnt++;
        end
        if (MemWrite) begin
            wr_cnt++;
            last_wa = Address;
            last_wd = Write_data;
        end
        if (done) dn_cnt++;
        if (MemRead && MemWrite) proto_err++;
        if (!MemRead && !MemWrite && Address != 32'h0) proto_err++;
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic load_str(input str_t s, input int base);
        int n;
        logic [7:0] c;
        n = 0;
        for (int i = 39; i >= 0; i--) begin
            c = s[i*8 +: 8];
            if (c != 8'h0) begin
                mem[base + n] = {24'h0, c};
                n++;
            end
        end
        mem[base + n] = 32'h0;
    endtask

    // Reference: plain substring counting over the truncated pattern.
    function automatic void model(input int txt[$], input int pt[$],
                                  output int cnt, output int pr,
                                  output int tr);
        int  pl;
        bit  ok;
        pl  = (pt.size() >= PAT_MAX) ? PAT_MAX : pt.size();
        pr  = (pt.size() >= PAT_MAX) ? PAT_MAX : pt.size() + 1;
        cnt = 0;
        tr  = 0;
        if (pl != 0) begin
            tr = txt.size() + 1;
            for (int i = 0; i + pl <= txt.size(); i++) begin
                ok = 1'b1;
                for (int j = 0; j < pl; j++) begin
                    if (txt[i+j] != pt[j]) ok = 1'b0;
                end
                if (ok) cnt++;
            end
        end
    endfunction

    task automatic run_case(input string nm, input int ecnt, input int epr,
                            input int etr, input bit extra);
        int pr0, tr0, wr0, dn0, lat;
        pr0 = pr_cnt;
        tr0 = tr_cnt;
        wr0 = wr_cnt;
        dn0 = dn_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = extra && !done && (lat % 7 == 3);
        end
        start = 1'b0;
        check({nm, " done_seen"}, 32'(done), 32'd1);
        check({nm, " latency"}, lat, epr + etr + 1 + WB);
        check({nm, " count"}, 32'(match_count), ecnt);
        check({nm, " busy_at_done"}, 32'(busy), 32'd1);
        check({nm, " pat_reads"}, pr_cnt - pr0, epr);
        check({nm, " text_reads"}, tr_cnt - tr0, etr);
        @(negedge clk);
        check({nm, " busy_after"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check({nm, " done_pulses"}, dn_cnt - dn0, 32'd1);
        check({nm, " writes"}, wr_cnt - wr0, WB);
        if (WB == 1) begin
            check({nm, " wr_addr"}, last_wa, RES_ADDR);
            check({nm, " wr_data"}, last_wd, ecnt);
        end
        check({nm, " count_held"}, 32'(match_count), ecnt);
    endtask

    vec_t vecs[8];

    initial begin
        int txt[$], pt[$];
        int ecnt, epr, etr, tl, pl, wr0, dn0;

        vecs[0] = '{text: "Linux is Not Unix is Unix is Unix", pat: "Unix",
                    cnt: 3, preads: 5, treads: 34};
        vecs[1] = '{text: "aaaa", pat: "aa", cnt: 3, preads: 3, treads: 5};
        vecs[2] = '{text: "hello", pat: "", cnt: 0, preads: 1, treads: 0};
        vecs[3] = '{text: "abcdefghijXabcdefgh", pat: "abcdefghij",
                    cnt: 2, preads: 8, treads: 20};
        vecs[4] = '{text: "", pat: "ab", cnt: 0, preads: 3, treads: 1};
        vecs[5] = '{text: "abab", pat: "abab", cnt: 1, preads: 5, treads: 5};
        vecs[6] = '{text: "xyz", pat: "xyzw", cnt: 0, preads: 5, treads: 4};
        vecs[7] = '{text: "ababa", pat: "aba", cnt: 2, preads: 4, treads: 6};

        clear_mem();
        #1 reset = 1'b0;
        #2;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst memread", 32'(MemRead), 32'd0);
        check("rst memwrite", 32'(MemWrite), 32'd0);
        check("rst address", Address, 32'h0);
        check("rst wdata", Write_data, 32'h0);
        check("rst count", 32'(match_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            clear_mem();
            load_str(vecs[i].text, 0);
            load_str(vecs[i].pat, 256);
            run_case($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].preads,
                     vecs[i].treads, 1'b0);
        end

        // Text fills every word below the pattern: stops on the read limit.
        clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h61;
        mem[256] = 32'h61;
        mem[257] = 32'h61;
        run_case("textmax", 255, 3, 256, 1'b0);

        // Extra start pulses while busy must be ignored.
        clear_mem();
        load_str("Linux is Not Unix is Unix is Unix", 0);
        load_str("Unix", 256);
        run_case("restart_ignored", 3, 5, 34, 1'b1);

        // Reset in the middle of the scan.
        clear_mem();
        load_str("abababababababababababababababababababab", 0);
        load_str("ab", 256);
        wr0 = wr_cnt;
        dn0 = dn_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_rst busy", 32'(busy), 32'd1);
        check("pre_rst memread", 32'(MemRead), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst memread", 32'(MemRead), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst count", 32'(match_count), 32'd0);
        check("midrst address", Address, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        check("midrst writes", wr_cnt - wr0, 32'd0);
        check("midrst dones", dn_cnt - dn0, 32'd0);

        for (int r = 0; r < 20; r++) begin
            clear_mem();
            txt.delete();
            pt.delete();
            tl = $urandom_range(0, 50);
            pl = $urandom_range(0, 10);
            for (int i = 0; i < tl; i++) begin
                txt.push_back(97 + $urandom_range(0, 1));
                mem[i] = 32'(txt[i]);
            end
            for (int i = 0; i < pl; i++) begin
                pt.push_back(97 + $urandom_range(0, 1));
                mem[256 + i] = 32'(pt[i]);
            end
            model(txt, pt, ecnt, epr, etr);
            run_case($sformatf("rnd%0d", r), ecnt, epr, etr,
                     ($urandom_range(0, 1) == 1));
        end

        check("bus_protocol", proto_err, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
